// File: rtl/two_phase_tx_sched_pkg.sv
// Shared types and helpers for the two-phase handshake transmit scheduler.
// Pure declarations: no logic, no latency, no flow control.
package two_phase_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 255;

    // Ceiling log2, floored at 1 so a degenerate parameter never yields a zero-width vector.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/two_phase_tx_sched_rr_arbiter.sv
// Round-robin picker: first valid index searching upward from ptr+1 with wrap.
// Combinational, zero latency; the pointer register lives in the parent.
module rr_arbiter
    import two_phase_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IW-1:0]   gnt_idx,
    output logic            any_vld
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any_vld = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!any_vld && req[cand]) begin
                any_vld       = 1'b1;
                gnt_idx       = cand;
                gnt_oh[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/two_phase_tx_sched.sv
// Shares one two-phase toggle handshake among NREQ requesters; grant registered one cycle after request.
// Holds hs_data until ack or timeout; late acks after a timeout are drained and never attributed.
module two_phase_tx_sched
    import two_phase_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clkA,
    input  logic                     rstA_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_done,
    output logic                     req_err,
    output logic                     hs_req,
    output logic [DW-1:0]            hs_data,
    input  logic                     hs_ack,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     to_err,
    output logic                     proto_err,
    input  logic                     err_clr
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] PTR_RST  = IW'(NREQ - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     grant_id_q, grant_id_d;
    logic [DW-1:0]     hs_data_q, hs_data_d;
    logic              hs_req_q, hs_req_d;
    logic [NREQ-1:0]   req_done_q, req_done_d;
    logic              req_err_q, req_err_d;
    logic              to_err_q, to_err_d;
    logic              proto_err_q, proto_err_d;

    logic [NREQ-1:0]   arb_oh;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;
    logic [DW-1:0]     pick_word;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .any_vld (arb_any)
    );

    always_comb begin
        pick_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_oh[i]) begin
                pick_word = pick_word | req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        grant_id_d  = grant_id_q;
        hs_data_d   = hs_data_q;
        hs_req_d    = 1'b0;
        req_done_d  = '0;
        req_err_d   = 1'b0;
        // Clear first so a same-cycle error event below overrides it.
        to_err_d    = to_err_q & ~err_clr;
        proto_err_d = proto_err_q & ~err_clr;

        case (state_q)
            IDLE: begin
                if (hs_ack) begin
                    proto_err_d = 1'b1;
                end
                if (arb_any) begin
                    grant_id_d = arb_idx;
                    hs_data_d  = pick_word;
                    hs_req_d   = 1'b1;
                    cnt_d      = '0;
                    ptr_d      = arb_idx;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                if (hs_ack) begin
                    req_done_d = NREQ'(1) << grant_id_q;
                    state_d    = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    req_done_d = NREQ'(1) << grant_id_q;
                    req_err_d  = 1'b1;
                    to_err_d   = 1'b1;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                // The aborted transfer's ack still arrives; swallow it so it is not credited to the next grant.
                if (hs_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkA or negedge rstA_n) begin
        if (!rstA_n) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_RST;
            cnt_q       <= '0;
            grant_id_q  <= '0;
            hs_data_q   <= '0;
            hs_req_q    <= 1'b0;
            req_done_q  <= '0;
            req_err_q   <= 1'b0;
            to_err_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            grant_id_q  <= grant_id_d;
            hs_data_q   <= hs_data_d;
            hs_req_q    <= hs_req_d;
            req_done_q  <= req_done_d;
            req_err_q   <= req_err_d;
            to_err_q    <= to_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign req_done  = req_done_q;
    assign req_err   = req_err_q;
    assign hs_req    = hs_req_q;
    assign hs_data   = hs_data_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_id_q;
    assign to_err    = to_err_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_two_phase_tx_sched.sv
// Directed bench for two_phase_tx_sched with NREQ=4, DW=8, TIMEOUT=8.
module tb_two_phase_tx_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_done;
    logic        req_err;
    logic        hs_req;
    logic [7:0]  hs_data;
    logic        hs_ack;
    logic        busy;
    logic [1:0]  grant_id;
    logic        to_err;
    logic        proto_err;
    logic        err_clr;

    int errors = 0;
    int checks = 0;

    two_phase_tx_sched #(
        .NREQ    (4),
        .DW      (8),
        .TIMEOUT (8)
    ) dut (
        .clkA      (clk),
        .rstA_n    (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_done  (req_done),
        .req_err   (req_err),
        .hs_req    (hs_req),
        .hs_data   (hs_data),
        .hs_ack    (hs_ack),
        .busy      (busy),
        .grant_id  (grant_id),
        .to_err    (to_err),
        .proto_err (proto_err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Polls at negedges until hs_req is seen; cyc is the number of negedges waited.
    task automatic wait_req(input int max_cyc, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (hs_req === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_data = '0; hs_ack = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({hs_req, req_done, req_err} !== 6'b0) begin
            errors++; $display("FAIL reset_pulses: got %b want 0", {hs_req, req_done, req_err});
        end
        checks++;
        if (hs_data !== 8'h00) begin
            errors++; $display("FAIL reset_hs_data: got %h want 00", hs_data);
        end
        checks++;
        if ({busy, grant_id, to_err, proto_err} !== 5'b0) begin
            errors++; $display("FAIL reset_status: got %b want 0", {busy, grant_id, to_err, proto_err});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle_after_release: busy=%b want 0", busy);
        end
    endtask

    task automatic test_fairness();
        bit seen; int cyc;
        logic [1:0] exp_id;
        logic [7:0] exp_dat;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            exp_id  = 2'(k % 4);
            exp_dat = 8'h10 + {6'b0, exp_id};
            wait_req(10, seen, cyc);
            checks++;
            if (!seen) begin
                errors++; $display("FAIL fair_req_%0d: hs_req=0 want 1 within 10 cycles", k);
            end
            checks++;
            if (grant_id !== exp_id || hs_data !== exp_dat) begin
                errors++;
                $display("FAIL fair_grant_%0d: id=%0d data=%h want id=%0d data=%h", k, grant_id, hs_data, exp_id, exp_dat);
            end
            @(negedge clk);
            hs_ack = 1'b1;
            @(negedge clk);
            hs_ack = 1'b0;
            if (k == 5) req_valid = 4'h0;
            checks++;
            if (req_done !== (4'b0001 << exp_id) || req_err !== 1'b0) begin
                errors++;
                $display("FAIL fair_done_%0d: done=%b err=%b want done=%b err=0", k, req_done, req_err, 4'b0001 << exp_id);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        bit seen; int cyc;
        req_data  = {8'h13, 8'h12, 8'h11, 8'hA5};
        req_valid = 4'b0001;
        wait_req(5, seen, cyc);
        checks++;
        if (!seen || cyc != 1) begin
            errors++; $display("FAIL single_latency: seen=%b cycles=%0d want seen=1 cycles=1", seen, cyc);
        end
        checks++;
        if (hs_data !== 8'hA5 || grant_id !== 2'd0) begin
            errors++; $display("FAIL single_data: data=%h id=%0d want A5 id=0", hs_data, grant_id);
        end
        @(negedge clk);
        checks++;
        if (hs_req !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_pulse_width: hs_req=%b busy=%b want 0 1", hs_req, busy);
        end
        @(negedge clk);
        hs_ack = 1'b1;
        @(negedge clk);
        hs_ack = 1'b0;
        checks++;
        if (req_done !== 4'b0001 || req_err !== 1'b0) begin
            errors++; $display("FAIL single_done: done=%b err=%b want 0001 0", req_done, req_err);
        end
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (req_done !== 4'b0000 || busy !== 1'b0 || hs_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_idle_hold: done=%b busy=%b data=%h want 0000 0 A5", req_done, busy, hs_data);
        end
    endtask

    task automatic test_timeout();
        bit seen; int cyc; int c; bit got; logic [3:0] stray;
        req_data  = {8'h13, 8'h3C, 8'h11, 8'hA5};
        req_valid = 4'b0100;
        wait_req(5, seen, cyc);
        checks++;
        if (!seen || grant_id !== 2'd2) begin
            errors++; $display("FAIL to_grant: seen=%b id=%0d want 1 2", seen, grant_id);
        end
        c = 0; got = 1'b0;
        while (!got && c < 20) begin
            @(negedge clk);
            c++;
            if (req_done !== 4'b0000) got = 1'b1;
        end
        checks++;
        if (!got || c != 8) begin
            errors++; $display("FAIL to_latency: done seen=%b after %0d cycles want 8", got, c);
        end
        checks++;
        if (req_done !== 4'b0100 || req_err !== 1'b1 || to_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_done: done=%b err=%b to_err=%b busy=%b want 0100 1 1 1", req_done, req_err, to_err, busy);
        end
        req_valid = 4'b0000;
        stray = 4'b0000;
        while (c < 19) begin
            @(negedge clk);
            c++;
            stray = stray | req_done;
        end
        hs_ack = 1'b1;
        @(negedge clk);
        hs_ack = 1'b0;
        stray = stray | req_done;
        checks++;
        if (stray !== 4'b0000 || busy !== 1'b0 || hs_data !== 8'h3C) begin
            errors++; $display("FAIL to_drain: stray=%b busy=%b data=%h want 0000 0 3C", stray, busy, hs_data);
        end
        req_data[7:0] = 8'h5A;
        req_valid     = 4'b0001;
        wait_req(5, seen, cyc);
        checks++;
        if (!seen || grant_id !== 2'd0 || hs_data !== 8'h5A) begin
            errors++; $display("FAIL to_next_grant: seen=%b id=%0d data=%h want 1 0 5A", seen, grant_id, hs_data);
        end
        @(negedge clk);
        hs_ack = 1'b1;
        @(negedge clk);
        hs_ack = 1'b0;
        req_valid = 4'b0000;
        checks++;
        if (req_done !== 4'b0001 || req_err !== 1'b0 || to_err !== 1'b1) begin
            errors++;
            $display("FAIL to_next_done: done=%b err=%b to_err=%b want 0001 0 1", req_done, req_err, to_err);
        end
        @(negedge clk);
    endtask

    task automatic test_spurious();
        hs_ack = 1'b1;
        @(negedge clk);
        hs_ack = 1'b0;
        checks++;
        if (proto_err !== 1'b1 || req_done !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL spur_flag: proto_err=%b done=%b busy=%b want 1 0000 0", proto_err, req_done, busy);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (proto_err !== 1'b0 || to_err !== 1'b0) begin
            errors++; $display("FAIL spur_clear: proto_err=%b to_err=%b want 0 0", proto_err, to_err);
        end
    endtask

    task automatic test_ack_vs_timeout();
        bit seen; int cyc;
        req_data  = {8'h77, 8'h3C, 8'h11, 8'h5A};
        req_valid = 4'b1000;
        wait_req(5, seen, cyc);
        checks++;
        if (!seen || grant_id !== 2'd3) begin
            errors++; $display("FAIL race_grant: seen=%b id=%0d want 1 3", seen, grant_id);
        end
        repeat (7) @(negedge clk);
        hs_ack = 1'b1;
        @(negedge clk);
        hs_ack = 1'b0;
        req_valid = 4'b0000;
        checks++;
        if (req_done !== 4'b1000 || req_err !== 1'b0 || to_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL race_ack_wins: done=%b err=%b to_err=%b busy=%b want 1000 0 0 0", req_done, req_err, to_err, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen; int cyc;
        req_data  = {8'h33, 8'hE7, 8'h22, 8'h11};
        req_valid = 4'b0100;
        wait_req(5, seen, cyc);
        checks++;
        if (!seen || grant_id !== 2'd2 || hs_data !== 8'hE7) begin
            errors++; $display("FAIL rst_pre_grant: seen=%b id=%0d data=%h want 1 2 E7", seen, grant_id, hs_data);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || hs_data !== 8'h00 || grant_id !== 2'd0 || {hs_req, req_done, req_err} !== 6'b0) begin
            errors++;
            $display("FAIL rst_async: busy=%b data=%h id=%0d pulses=%b want 0 00 0 0", busy, hs_data, grant_id, {hs_req, req_done, req_err});
        end
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1001;
        wait_req(5, seen, cyc);
        checks++;
        if (!seen || grant_id !== 2'd0 || hs_data !== 8'h11) begin
            errors++; $display("FAIL rst_ptr_restart: seen=%b id=%0d data=%h want 1 0 11", seen, grant_id, hs_data);
        end
        @(negedge clk);
        hs_ack = 1'b1;
        @(negedge clk);
        hs_ack = 1'b0;
        req_valid = 4'b0000;
        checks++;
        if (req_done !== 4'b0001 || req_err !== 1'b0) begin
            errors++; $display("FAIL rst_post_done: done=%b err=%b want 0001 0", req_done, req_err);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_timeout();
        test_spurious();
        test_ack_vs_timeout();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
